// File: rtl/note_scheduler.sv
`timescale 1ns/1ps
// Rhythm-game note scheduler: buffers chart events, counts their delays down in beat ticks,
// opens a hit window on the due lanes and judges key presses into hit/miss, score and combo.
module note_scheduler #(
    parameter int LANES     = 4,
    parameter int DLY_W     = 8,
    parameter int DEPTH     = 8,
    parameter int WIN_TICKS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             ev_valid,
    output logic             ev_ready,
    input  logic [LANES-1:0] ev_lane,
    input  logic [DLY_W-1:0] ev_delay,
    input  logic             tick,
    input  logic [LANES-1:0] key,
    output logic [LANES-1:0] marker,
    output logic             hit,
    output logic             miss,
    output logic [15:0]      score,
    output logic [7:0]       combo,
    output logic             busy,
    output logic             done
);

    localparam int AW    = $clog2(DEPTH);
    localparam int WIN_W = $clog2(WIN_TICKS + 1);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, WINDOW, RESOLVE} state_t;

    state_t state, state_n;

    logic [LANES+DLY_W-1:0] mem [DEPTH];
    logic [AW:0]            wr_ptr, rd_ptr;
    logic                   empty, full, push, pop;

    logic [DLY_W-1:0] dly;
    logic [LANES-1:0] mask, got, key_hit;
    logic [WIN_W-1:0] win;
    logic             all_got;
    logic             hit_q, miss_q, done_q;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push     = ev_valid && !full;
    assign pop      = (state == FETCH) && !empty;
    assign ev_ready = !full;

    assign key_hit = key & mask;
    assign all_got = ((got | key_hit) == mask);

    assign marker = (state == WINDOW) ? mask : '0;
    assign busy   = (state != IDLE);
    assign hit    = hit_q;
    assign miss   = miss_q;
    assign done   = done_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {ev_lane, ev_delay};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = FETCH;
            FETCH:   state_n = empty ? IDLE : WAIT;
            WAIT:    if (dly == '0) state_n = (mask == '0) ? FETCH : WINDOW;
            WINDOW: begin
                // A completing key wins over a window-closing tick in the same cycle.
                if (all_got) state_n = RESOLVE;
                else if (tick && win == WIN_W'(1)) state_n = RESOLVE;
            end
            RESOLVE: state_n = FETCH;
            default: state_n = IDLE;
        endcase
    end

    // Judgement results are registered on entry to RESOLVE so hit/miss and the updated
    // score/combo are all visible during the RESOLVE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dly    <= '0;
            mask   <= '0;
            got    <= '0;
            win    <= '0;
            score  <= '0;
            combo  <= '0;
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        score <= '0;
                        combo <= '0;
                    end
                end
                FETCH: begin
                    if (empty) done_q <= 1'b1;
                    else       {mask, dly} <= mem[rd_ptr[AW-1:0]];
                end
                WAIT: begin
                    if (dly == '0) begin
                        win <= WIN_W'(WIN_TICKS);
                        got <= '0;
                    end else if (tick) begin
                        dly <= dly - DLY_W'(1);
                    end
                end
                WINDOW: begin
                    got <= got | key_hit;
                    if (all_got) begin
                        hit_q <= 1'b1;
                        if (score != 16'hFFFF) score <= score + 16'd1;
                        if (combo != 8'hFF)    combo <= combo + 8'd1;
                    end else if (tick) begin
                        win <= win - WIN_W'(1);
                        if (win == WIN_W'(1)) begin
                            miss_q <= 1'b1;
                            combo  <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_note_scheduler.sv
`timescale 1ns/1ps
// Directed bench for note_scheduler: hit/miss results are queued as expected when a window is
// driven and popped by a monitor when the DUT pulses hit or miss.
module tb_note_scheduler;

    logic       clk = 1'b0;
    logic       reset, start, ev_valid, tick;
    logic       ev_ready, hit, miss, busy, done;
    logic [3:0] ev_lane, key, marker;
    logic [7:0] ev_delay, combo;
    logic [15:0] score;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic        is_hit;
        logic [15:0] score;
        logic [7:0]  combo;
    } exp_t;

    exp_t sb[$];

    note_scheduler #(.LANES(4), .DLY_W(8), .DEPTH(8), .WIN_TICKS(2)) dut (
        .clk(clk), .reset(reset), .start(start), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_lane(ev_lane), .ev_delay(ev_delay), .tick(tick), .key(key), .marker(marker),
        .hit(hit), .miss(miss), .score(score), .combo(combo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] lane, input logic [7:0] dly);
        ev_valid = 1'b1;
        ev_lane  = lane;
        ev_delay = dly;
        cycle();
        ev_valid = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cycle();
        tick = 1'b0;
    endtask

    task automatic press(input logic [3:0] k);
        key = k;
        cycle();
        key = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_window(input logic [3:0] expected);
        int n = 0;
        @(negedge clk);
        while (marker == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("window_marker", 32'(marker), 32'(expected));
    endtask

    task automatic wait_done();
        int  n = 0;
        logic seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            n++;
        end
        checkOutput("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic expect_result(input logic is_hit, input logic [15:0] s, input logic [7:0] c);
        exp_t e;
        e.is_hit = is_hit;
        e.score  = s;
        e.combo  = c;
        sb.push_back(e);
    endtask

    // Every hit/miss pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && (hit || miss)) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_result", {30'd0, hit, miss}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("result_hit",   32'(hit),   32'(e.is_hit));
                checkOutput("result_miss",  32'(miss),  32'(!e.is_hit));
                checkOutput("result_score", 32'(score), 32'(e.score));
                checkOutput("result_combo", 32'(combo), 32'(e.combo));
            end
        end
    end

    initial begin
        logic [3:0] seq [4];
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b1000; seq[3] = 4'b0100;

        reset = 1'b1; start = 1'b0; ev_valid = 1'b0; tick = 1'b0;
        ev_lane = '0; ev_delay = '0; key = '0;
        repeat (3) cycle();
        @(negedge clk);
        checkOutput("reset_marker",   32'(marker),   32'd0);
        checkOutput("reset_busy",     32'(busy),     32'd0);
        checkOutput("reset_ev_ready", 32'(ev_ready), 32'd1);
        checkOutput("reset_score",    32'(score),    32'd0);
        checkOutput("reset_flags",    {29'd0, hit, miss, done}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Run 1: single note, delay 3.
        applyStimulus(4'b0001, 8'd3);
        pulse_start();
        @(negedge clk);
        checkOutput("run1_busy", 32'(busy), 32'd1);
        cycle();
        pulse_tick();
        pulse_tick();
        @(negedge clk);
        checkOutput("run1_marker_before_3rd_tick", 32'(marker), 32'd0);
        pulse_tick();
        wait_window(4'b0001);
        expect_result(1'b1, 16'd1, 8'd1);
        press(4'b0001);
        @(negedge clk);
        checkOutput("run1_hit_latency", 32'(hit), 32'd1);
        wait_done();
        checkOutput("run1_score", 32'(score), 32'd1);
        checkOutput("run1_combo", 32'(combo), 32'd1);
        checkOutput("run1_busy_end", 32'(busy), 32'd0);

        // Run 2: fill FIFO with 8 events, hold a 9th until the first pop.
        applyStimulus(4'b0101, 8'd0);
        for (int i = 0; i < 4; i++) applyStimulus(seq[i], 8'd0);
        applyStimulus(4'b0010, 8'd0);
        applyStimulus(4'b0000, 8'd2);
        @(negedge clk);
        checkOutput("fifo_ready_at_7", 32'(ev_ready), 32'd1);
        applyStimulus(4'b0001, 8'd0);
        @(negedge clk);
        checkOutput("fifo_full_at_8", 32'(ev_ready), 32'd0);
        ev_valid = 1'b1; ev_lane = 4'b1000; ev_delay = 8'd0;
        repeat (3) cycle();
        @(negedge clk);
        checkOutput("fifo_9th_held", 32'(ev_ready), 32'd0);
        pulse_start();
        @(negedge clk);
        checkOutput("run2_ready_in_fetch", 32'(ev_ready), 32'd0);
        checkOutput("run2_score_cleared", 32'(score), 32'd0);
        cycle();
        @(negedge clk);
        checkOutput("run2_ready_after_pop", 32'(ev_ready), 32'd1);
        cycle();
        ev_valid = 1'b0;

        // Chord: both lanes needed, off-mask key ignored.
        wait_window(4'b0101);
        expect_result(1'b1, 16'd1, 8'd1);
        press(4'b0010);
        @(negedge clk);
        checkOutput("chord_offmask_no_hit", 32'(hit), 32'd0);
        press(4'b0001);
        cycle();
        @(negedge clk);
        checkOutput("chord_partial_no_hit", 32'(hit), 32'd0);
        checkOutput("chord_marker_held", 32'(marker), 32'b0101);
        press(4'b0100);
        @(negedge clk);
        checkOutput("chord_hit", 32'(hit), 32'd1);

        for (int i = 0; i < 4; i++) begin
            wait_window(seq[i]);
            expect_result(1'b1, 16'(i + 2), 8'(i + 2));
            press(seq[i]);
        end

        // Miss after two ticks with no key.
        wait_window(4'b0010);
        expect_result(1'b0, 16'd5, 8'd0);
        pulse_tick();
        @(negedge clk);
        checkOutput("miss_not_after_1st_tick", 32'(miss), 32'd0);
        pulse_tick();
        @(negedge clk);
        checkOutput("miss_pulse", 32'(miss), 32'd1);

        // Rest event consumes two ticks silently.
        cycle();
        cycle();
        cycle();
        pulse_tick();
        pulse_tick();

        // Key together with the closing tick counts as a hit.
        wait_window(4'b0001);
        expect_result(1'b1, 16'd6, 8'd1);
        pulse_tick();
        key = 4'b0001;
        pulse_tick();
        key = '0;
        @(negedge clk);
        checkOutput("key_tick_same_cycle_hit", 32'(hit), 32'd1);
        checkOutput("key_tick_same_cycle_miss", 32'(miss), 32'd0);

        wait_window(4'b1000);
        expect_result(1'b1, 16'd7, 8'd2);
        press(4'b1000);
        wait_done();
        checkOutput("run2_score", 32'(score), 32'd7);
        checkOutput("run2_combo", 32'(combo), 32'd2);

        // Run 3: reset mid-window with three events still queued.
        applyStimulus(4'b0001, 8'd0);
        applyStimulus(4'b0010, 8'd0);
        applyStimulus(4'b0100, 8'd0);
        applyStimulus(4'b1000, 8'd0);
        applyStimulus(4'b0001, 8'd0);
        pulse_start();
        wait_window(4'b0001);
        expect_result(1'b1, 16'd1, 8'd1);
        press(4'b0001);
        wait_window(4'b0010);
        reset = 1'b1;
        #1;
        checkOutput("midreset_marker",   32'(marker),   32'd0);
        checkOutput("midreset_busy",     32'(busy),     32'd0);
        checkOutput("midreset_ev_ready", 32'(ev_ready), 32'd1);
        checkOutput("midreset_score",    32'(score),    32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        pulse_start();
        @(negedge clk);
        checkOutput("empty_start_done_early", 32'(done), 32'd0);
        cycle();
        @(negedge clk);
        checkOutput("empty_start_done", 32'(done), 32'd1);
        checkOutput("empty_start_idle", 32'(busy), 32'd0);
        repeat (3) cycle();

        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
